if_id_stage: RTL and testbench

- Pipeline boundary between the Fetch stage and Decode.
- Captures (PC, Instruction) pairs that Fetch delivers on a cache hit. Holds them in a 2-entry elastic queue and presents them to Decode with a valid/ready handshake.
- Discards wrong-path instructions on a taken branch (Flush) and inserts bubbles on cache misses.
- Drives a stall back to Fetch when the queue is full.

---
 rtl/if_id_pkg.sv | 21 ++
 rtl/fetch_queue.sv | 95 +++++++++
 rtl/if_id_stage.sv | 129 ++++++++++++
 tb/tb_if_id_stage.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/if_id_pkg.sv
// -----------------------------------------------------------------------------
// if_id_pkg
// Shared definitions for the IF/ID pipeline boundary and later decode stages.
//   ADDR_W     default PC width
//   INSTR_W    default instruction width
//   NOP_INSTR  encoding presented to Decode when no instruction is available
//   fetch_pkt_t  (pc, instr) pair as delivered by Fetch on a cache hit
// -----------------------------------------------------------------------------
package if_id_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_pkt_t;

endpackage : if_id_pkg

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Generic synchronous FIFO of packets (default fetch_pkt_t). Reads are a
// combinational view of the entry at the read pointer; a written entry
// becomes visible only after the clock edge that stores it.
// Ports:
//   clk_i     clock (rising edge)
//   rst_ni    synchronous active-low reset, highest priority
//   clear_i   drop every entry and rewind both pointers
//   push_i    write data_i at the write pointer (ignored when full)
//   pop_i     advance the read pointer (ignored when empty)
//   data_i    packet to store
//   data_o    packet at the read pointer (stale when empty)
//   full_o    count == DEPTH
//   empty_o   count == 0
//   count_o   number of stored entries
// -----------------------------------------------------------------------------
module fetch_queue
    import if_id_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_pkt_t,
    parameter int  PTR_W = $clog2(DEPTH),
    parameter int  CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  T                 data_i,
    output T                 data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    T                 mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latch).
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push_ok) wptr_d = wptr_q + PTR_W'(1);
            if (pop_ok)  rptr_d = rptr_q + PTR_W'(1);
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only observable once count covers it.
    always_ff @(posedge clk_i) begin
        if (rst_ni && !clear_i && push_ok) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule : fetch_queue

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// Fetch -> Decode pipeline boundary. Captures (PC, instruction) pairs on a
// cache hit into a DEPTH-entry elastic queue, presents the head to Decode
// with a valid/ready handshake, discards everything on a taken-branch Flush
// and stalls Fetch while the queue is full.
// Ports:
//   Clock              clock (rising edge)
//   Reset_n            synchronous active-low reset
//   FetchPC            PC presented by Fetch
//   FetchInstruction   instruction word from the instruction cache
//   FetchHit           FetchPC/FetchInstruction valid this cycle
//   Flush              taken branch; current and queued instructions are wrong-path
//   DecodeReady        Decode accepts the head entry
//   DecodeValid        head entry valid
//   DecodePC           head PC (0 when empty)
//   DecodeInstruction  head instruction (NOP when empty)
//   FetchStall         queue full; Fetch holds its PC
//   PerfDelivered      saturating count of pops          (IF_ID_PERF_EN only)
//   PerfBubbles        saturating count of starved cycles (IF_ID_PERF_EN only)
// Optional feature macro: IF_ID_PERF_EN
// -----------------------------------------------------------------------------
module if_id_stage
    import if_id_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int ADDR_W  = if_id_pkg::ADDR_W,
    parameter int INSTR_W = if_id_pkg::INSTR_W
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic [ADDR_W-1:0]  FetchPC,
    input  logic [INSTR_W-1:0] FetchInstruction,
    input  logic               FetchHit,
    input  logic               Flush,
    input  logic               DecodeReady,
    output logic               DecodeValid,
    output logic [ADDR_W-1:0]  DecodePC,
    output logic [INSTR_W-1:0] DecodeInstruction,
    output logic               FetchStall
`ifdef IF_ID_PERF_EN
    ,
    output logic [31:0]        PerfDelivered,
    output logic [31:0]        PerfBubbles
`endif
);

    // Same layout as fetch_pkt_t, but tracking this instance's widths.
    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } pkt_t;

    localparam int CNT_W = $clog2(DEPTH) + 1;

    pkt_t             wr_pkt;
    pkt_t             head_pkt;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    logic             push;
    logic             pop;

    assign wr_pkt = '{pc: FetchPC, instr: FetchInstruction};

    // Flush wins over both push and pop. FetchStall comes from the registered
    // count only, so DecodeReady never reaches it combinationally.
    assign push = FetchHit & ~q_full & ~Flush;
    assign pop  = DecodeValid & DecodeReady & ~Flush;

    fetch_queue #(
        .DEPTH (DEPTH),
        .T     (pkt_t)
    ) u_queue (
        .clk_i   (Clock),
        .rst_ni  (Reset_n),
        .clear_i (Flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (wr_pkt),
        .data_o  (head_pkt),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign DecodeValid = ~q_empty;
    assign FetchStall  = q_full;

    // Mask stale storage so an empty queue always shows PC 0 / NOP.
    always_comb begin
        DecodePC          = '0;
        DecodeInstruction = INSTR_W'(NOP_INSTR);
        if (!q_empty) begin
            DecodePC          = head_pkt.pc;
            DecodeInstruction = head_pkt.instr;
        end
    end

`ifdef IF_ID_PERF_EN
    logic [31:0] delivered_q, delivered_d;
    logic [31:0] bubbles_q, bubbles_d;

    always_comb begin
        delivered_d = delivered_q;
        bubbles_d   = bubbles_q;
        if (pop && (delivered_q != '1))                       delivered_d = delivered_q + 32'd1;
        if (DecodeReady && !DecodeValid && (bubbles_q != '1)) bubbles_d   = bubbles_q + 32'd1;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            delivered_q <= '0;
            bubbles_q   <= '0;
        end else begin
            delivered_q <= delivered_d;
            bubbles_q   <= bubbles_d;
        end
    end

    assign PerfDelivered = delivered_q;
    assign PerfBubbles   = bubbles_q;
`endif

    // Occupancy is fully reflected by full/empty at this boundary.
    logic unused_count;
    assign unused_count = ^q_count;

endmodule : if_id_stage

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
// Directed steps followed by a randomized phase. The reference is a plain
// queue of (pc, instr) pairs updated once per clock from the handshake rules;
// every cycle the DUT outputs are compared against the queue head.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

    localparam int          DEPTH   = 2;
    localparam int          ADDR_W  = 64;
    localparam int          INSTR_W = 32;
    localparam logic [31:0] NOP     = 32'hD503201F;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [ADDR_W-1:0]  fetch_pc;
    logic [INSTR_W-1:0] fetch_instr;
    logic               fetch_hit;
    logic               flush;
    logic               decode_ready;
    logic               decode_valid;
    logic [ADDR_W-1:0]  decode_pc;
    logic [INSTR_W-1:0] decode_instr;
    logic               fetch_stall;

    always #5 clk = ~clk;

    if_id_stage #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .Clock             (clk),
        .Reset_n           (rst_n),
        .FetchPC           (fetch_pc),
        .FetchInstruction  (fetch_instr),
        .FetchHit          (fetch_hit),
        .Flush             (flush),
        .DecodeReady       (decode_ready),
        .DecodeValid       (decode_valid),
        .DecodePC          (decode_pc),
        .DecodeInstruction (decode_instr),
        .FetchStall        (fetch_stall)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } pair_t;

    pair_t model_q[$];
    int    checks = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [63:0] pc);
        return 32'hE000_0000 ^ pc[31:0];
    endfunction

    task automatic drive(input logic r, input logic hit, input logic fl, input logic rdy,
                         input logic [63:0] pc);
        rst_n        = r;
        fetch_hit    = hit;
        flush        = fl;
        decode_ready = rdy;
        fetch_pc     = pc;
        fetch_instr  = instr_of(pc);
    endtask

    // Reference: what the queue holds after this edge, from the rules alone.
    task automatic model_step();
        bit do_pop;
        bit do_push;
        if (!rst_n || flush) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() != 0) && decode_ready;
            do_push = fetch_hit && (model_q.size() < DEPTH);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back('{pc: fetch_pc, instr: fetch_instr});
        end
    endtask

    task automatic compare_model(input string tag);
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        exp_pc    = (model_q.size() != 0) ? model_q[0].pc : 64'd0;
        exp_instr = (model_q.size() != 0) ? model_q[0].instr : NOP;
        check({tag, ".valid"}, decode_valid, model_q.size() != 0);
        check({tag, ".pc"},    decode_pc,    exp_pc);
        check({tag, ".instr"}, decode_instr, exp_instr);
        check({tag, ".stall"}, fetch_stall,  model_q.size() == DEPTH);
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clk);
        #1;
        compare_model(tag);
    endtask

    initial begin
        drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h500);

        // Reset held for two cycles with a hit presented.
        tick("reset0");
        tick("reset1");
        check("reset_valid", decode_valid, 1'b0);
        check("reset_instr", decode_instr, NOP);
        check("reset_pc",    decode_pc,    64'd0);
        check("reset_stall", fetch_stall,  1'b0);

        // Streaming: each pushed PC is the head one cycle later.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h0);  tick("stream");
        check("stream_pc0", decode_pc, 64'h0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h4);  tick("stream");
        check("stream_pc1", decode_pc, 64'h4);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h8);  tick("stream");
        check("stream_pc2", decode_pc, 64'h8);
        check("stream_stall", fetch_stall, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0);  tick("stream_drain");
        check("stream_empty", decode_valid, 1'b0);

        // Backpressure: fill, present 0x108 while full, then drain.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h100); tick("bp");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h104); tick("bp");
        check("bp_stall_full", fetch_stall, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h108); tick("bp_hold");
        check("bp_head_100", decode_pc, 64'h100);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h108); tick("bp_pop1");
        check("bp_head_104", decode_pc, 64'h104);
        check("bp_stall_released", fetch_stall, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0);   tick("bp_pop2");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0);   tick("bp_pop3");
        check("bp_drained", decode_valid, 1'b0);

        // Miss bubbles: hit 1,0,0,1 gives valid 1,0,0,1 one cycle later.
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h20); tick("miss");
        check("miss_v0", decode_valid, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0);  tick("miss");
        check("miss_v1", decode_valid, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0);  tick("miss");
        check("miss_v2", decode_valid, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h24); tick("miss");
        check("miss_v3", decode_valid, 1'b1);
        check("miss_pc3", decode_pc, 64'h24);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0);  tick("miss_drain");

        // Flush against a full queue with a hit presented.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h40); tick("flush_fill");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h44); tick("flush_fill");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h48); tick("flush");
        check("flush_valid", decode_valid, 1'b0);
        check("flush_stall", fetch_stall,  1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h200); tick("flush_next");
        check("flush_next_pc", decode_pc, 64'h200);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h204); tick("flush_b2b0");
        drive(1'b1, 1'b1, 1'b1, 1'b1, 64'h208); tick("flush_b2b1");
        check("flush_b2b_valid", decode_valid, 1'b0);

        // Simultaneous push and pop with one entry queued.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h60); tick("simul_fill");
        check("simul_head_60", decode_pc, 64'h60);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 64'h64); tick("simul");
        check("simul_head_64", decode_pc, 64'h64);
        check("simul_count1", fetch_stall, 1'b0);

        // Empty boundary: ready with nothing queued must not underflow.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0); tick("empty0");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0); tick("empty1");
        drive(1'b1, 1'b0, 1'b0, 1'b1, 64'h0); tick("empty2");
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h70); tick("empty_then_push");
        check("empty_no_underflow", decode_pc, 64'h70);

        // Reset mid-operation beats push and pop.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 64'h74); tick("midrst_fill");
        drive(1'b0, 1'b1, 1'b0, 1'b1, 64'h78); tick("midrst");
        check("midrst_valid", decode_valid, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic [63:0] pc;
            pc = {32'd0, $urandom} & 64'h0000_0000_FFFF_FFFC;
            drive(($urandom % 60) != 0,
                  ($urandom % 4) != 0,
                  ($urandom % 12) == 0,
                  ($urandom % 3) != 0,
                  pc);
            fetch_instr = $urandom;
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_if_id_stage
